// File: rtl/axi_lite_master.sv
// Single-outstanding bridge from the datapath memory request port to a 32-bit AXI4-Lite master.
// Every AXI valid/ready output and the datapath ready/bus_err are registered from the next-state decode.
module axi_lite_master #(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read,
  input  logic [1:0]  write,
  input  logic [31:0] addr,
  input  logic [31:0] store,
  input  logic        done,
  output logic        ready,
  output logic [31:0] load,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, DONE} state_t;

  state_t      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_d;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd1:    lane_strb = 4'b0001 << off;
      2'd2:    lane_strb = 4'b0011 << {off[1], 1'b0};
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated across the word so the strobes alone select the lanes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd1:    lane_data = {4{data[7:0]}};
      2'd2:    lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (write != 2'd0) begin
          state_d   = WADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (read) begin
          state_d = RADDR;
        end
      end
      RADDR: if (m_arvalid && m_arready) state_d = RDATA;
      RDATA: begin
        if (m_rready && m_rvalid) begin
          state_d = DONE;
          err_d   = m_rresp[1];
        end
      end
      WADDR: begin
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_bready && m_bvalid) begin
          state_d = DONE;
          err_d   = m_bresp[1];
        end
      end
      DONE:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      ready     <= 1'b0;
      bus_err   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      load      <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      m_arvalid <= (state_d == RADDR);
      m_rready  <= (state_d == RDATA);
      m_awvalid <= (state_d == WADDR) && !aw_done_d;
      m_wvalid  <= (state_d == WADDR) && !w_done_d;
      m_bready  <= (state_d == WRESP);
      ready     <= (state_d == DONE);
      bus_err   <= err_d;
      // Request is captured only when leaving IDLE; later input changes are ignored.
      if (state_q == IDLE && (write != 2'd0 || read)) begin
        addr_q <= addr[31:2];
        if (write != 2'd0) begin
          wstrb_q <= lane_strb(write, addr[1:0]);
          wdata_q <= lane_data(write, store);
        end
      end
      if (state_q == RDATA && m_rvalid) load <= m_rdata;
    end
  end

  assign m_araddr = {addr_q, 2'b00};
  assign m_awaddr = {addr_q, 2'b00};
  assign m_arprot = PROT;
  assign m_awprot = PROT;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;

endmodule
